// File: rtl/md_pkg.sv
// Shared encodings and sizes for the execute-stage multiply/divide unit.
package md_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MD_ITER = 32;
    localparam int unsigned CNT_W   = 6;

    // md_opE encodings; 6 and 7 are reserved and act as no-ops
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } mdOp_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_SIGN = 2'd2
    } mdState_t;

endpackage

// File: rtl/md_negate.sv
// Conditional two's-complement negate.
//   negate    : when high, the output is -value, otherwise value
//   value     : W-bit operand
//   negated_c : combinational result
module md_negate #(
    parameter int unsigned W = 32
) (
    input  logic         negate,
    input  logic [W-1:0] value,
    output logic [W-1:0] negated_c
);

    always_comb begin
        negated_c = negate ? W'(~value + W'(1)) : value;
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative multiply/divide unit holding the architectural HI/LO.
//   CLOCK, RESET_N : clock, synchronous active-low reset
//   md_startE      : valid multiply/divide-class op in EX
//   md_opE         : operation select (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   rs_valueE      : dividend / multiplicand / MTHI-MTLO source
//   rt_valueE      : divisor / multiplier
//   hiE, loE       : architectural HI/LO registers
//   md_busy        : iterative op in progress (decoded from state)
//   md_done        : one-cycle pulse after HI/LO take a mul/div result
module ex_muldiv_unit
    import md_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    input  logic            md_startE,
    input  logic [2:0]      md_opE,
    input  logic [XLEN-1:0] rs_valueE,
    input  logic [XLEN-1:0] rt_valueE,
    output logic [XLEN-1:0] hiE,
    output logic [XLEN-1:0] loE,
    output logic            md_busy,
    output logic            md_done
);

    localparam int unsigned W2 = 2 * XLEN;

    mdState_t         state, stateNext;
    logic [CNT_W-1:0] count, countNext;
    logic [W2-1:0]    work, workNext;
    logic [XLEN-1:0]  opB, opBNext;
    logic             isDiv, isDivNext;
    logic             signFlag, signFlagNext;
    logic             remFlag, remFlagNext;
    logic             divZero, divZeroNext;
    logic [XLEN-1:0]  hiNext, loNext;
    logic             doneNext;

    logic             signedOp;
    logic [XLEN-1:0]  rsMag, rtMag;
    logic [XLEN:0]    mulSum;
    logic [W2-1:0]    mulStep;
    logic [XLEN:0]    shiftedRem;
    logic             divFits;
    logic [XLEN-1:0]  divRem;
    logic [W2-1:0]    divStep;
    logic [W2-1:0]    prodFix;
    logic [XLEN-1:0]  quotFix, remFix;

    assign md_busy  = (state != MD_IDLE);
    assign signedOp = (md_opE == MD_MULT) || (md_opE == MD_DIV);

    // Operand magnitudes for signed ops
    md_negate #(.W(XLEN)) uRsMag (
        .negate    (signedOp & rs_valueE[XLEN-1]),
        .value     (rs_valueE),
        .negated_c (rsMag)
    );

    md_negate #(.W(XLEN)) uRtMag (
        .negate    (signedOp & rt_valueE[XLEN-1]),
        .value     (rt_valueE),
        .negated_c (rtMag)
    );

    // Result sign fix-up applied in SIGN
    md_negate #(.W(W2)) uProdFix (
        .negate    (signFlag),
        .value     (work),
        .negated_c (prodFix)
    );

    md_negate #(.W(XLEN)) uQuotFix (
        .negate    (signFlag),
        .value     (work[XLEN-1:0]),
        .negated_c (quotFix)
    );

    md_negate #(.W(XLEN)) uRemFix (
        .negate    (remFlag),
        .value     (work[W2-1:XLEN]),
        .negated_c (remFix)
    );

    // Multiply step: work = {acc, multiplier}; add multiplicand on LSB, shift right with carry
    always_comb begin
        mulSum  = {1'b0, work[W2-1:XLEN]} + {1'b0, (work[0] ? opB : XLEN'(0))};
        mulStep = {mulSum, work[XLEN-1:1]};
    end

    // Restoring divide step: work = {remainder, quotient}; shift left, trial subtract
    always_comb begin
        shiftedRem = work[W2-1:XLEN-1];
        divFits    = (shiftedRem >= {1'b0, opB});
        divRem     = XLEN'(shiftedRem - {1'b0, opB});
        divStep    = divFits ? {divRem, work[XLEN-2:0], 1'b1}
                             : {work[W2-2:0], 1'b0};
    end

    // Next-state and datapath control
    always_comb begin
        stateNext    = state;
        countNext    = count;
        workNext     = work;
        opBNext      = opB;
        isDivNext    = isDiv;
        signFlagNext = signFlag;
        remFlagNext  = remFlag;
        divZeroNext  = divZero;
        hiNext       = hiE;
        loNext       = loE;
        doneNext     = 1'b0;

        case (state)
            MD_IDLE: begin
                if (md_startE) begin
                    case (md_opE)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            isDivNext    = md_opE[1];
                            signFlagNext = signedOp & (rs_valueE[XLEN-1] ^ rt_valueE[XLEN-1]);
                            remFlagNext  = signedOp & rs_valueE[XLEN-1];
                            divZeroNext  = (rt_valueE == XLEN'(0));
                            countNext    = '0;
                            stateNext    = MD_CALC;
                            if (md_opE[1]) begin
                                workNext = {XLEN'(0), rsMag};
                                opBNext  = rtMag;
                            end else begin
                                workNext = {XLEN'(0), rtMag};
                                opBNext  = rsMag;
                            end
                        end
                        MD_MTHI: hiNext = rs_valueE;
                        MD_MTLO: loNext = rs_valueE;
                        default: ;
                    endcase
                end
            end
            MD_CALC: begin
                workNext  = isDiv ? divStep : mulStep;
                countNext = count + CNT_W'(1);
                if (count == CNT_W'(MD_ITER - 1)) begin
                    stateNext = MD_SIGN;
                end
            end
            MD_SIGN: begin
                if (isDiv) begin
                    hiNext = remFix;
                    // Divide by zero yields an all-ones quotient regardless of sign
                    loNext = divZero ? '1 : quotFix;
                end else begin
                    {hiNext, loNext} = prodFix;
                end
                doneNext  = 1'b1;
                stateNext = MD_IDLE;
            end
            default: stateNext = MD_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state    <= MD_IDLE;
            count    <= '0;
            work     <= '0;
            opB      <= '0;
            isDiv    <= 1'b0;
            signFlag <= 1'b0;
            remFlag  <= 1'b0;
            divZero  <= 1'b0;
            hiE      <= '0;
            loE      <= '0;
            md_done  <= 1'b0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            work     <= workNext;
            opB      <= opBNext;
            isDiv    <= isDivNext;
            signFlag <= signFlagNext;
            remFlag  <= remFlagNext;
            divZero  <= divZeroNext;
            hiE      <= hiNext;
            loE      <= loNext;
            md_done  <= doneNext;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;
    import md_pkg::*;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic        md_startE;
    logic [2:0]  md_opE;
    logic [31:0] rs_valueE;
    logic [31:0] rt_valueE;
    logic [31:0] hiE;
    logic [31:0] loE;
    logic        md_busy;
    logic        md_done;

    int checks = 0;
    int errors = 0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;

    always #5 CLOCK = ~CLOCK;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .md_startE (md_startE),
        .md_opE    (md_opE),
        .rs_valueE (rs_valueE),
        .rt_valueE (rt_valueE),
        .hiE       (hiE),
        .loE       (loE),
        .md_busy   (md_busy),
        .md_done   (md_done)
    );

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Architectural result of one operation, from plain integer arithmetic
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      inout logic [31:0] hi, inout logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT: begin
                p = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            MD_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            MD_DIV: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    hi = 32'(r);
                    lo = 32'(q);
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    hi = a % b;
                    lo = a / b;
                end
            end
            MD_MTHI: hi = a;
            MD_MTLO: lo = a;
            default: ;
        endcase
    endfunction

    // Issue one iterative op at cycle T and check everything up to cycle T+34 (where it returns)
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name, input bit inject);
        logic [31:0] hi0, lo0;
        int busyCycles;
        bit earlyDone, hiloMoved;
        hi0 = expHi;
        lo0 = expLo;
        ref_model(op, a, b, expHi, expLo);
        md_startE = 1'b1;
        md_opE    = op;
        rs_valueE = a;
        rt_valueE = b;
        tick();
        busyCycles = 0;
        earlyDone  = 1'b0;
        hiloMoved  = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (md_busy === 1'b1) busyCycles++;
            if (md_done !== 1'b0) earlyDone = 1'b1;
            if (hiE !== hi0 || loE !== lo0) hiloMoved = 1'b1;
            md_startE = inject && (c == 5);
            md_opE    = inject ? 3'(MD_MULTU) : 3'($urandom);
            rs_valueE = $urandom;
            rt_valueE = $urandom;
            tick();
        end
        md_startE = 1'b0;
        checks++;
        if (busyCycles !== 33) begin
            errors++;
            $display("FAIL %s busy_len: busy cycles=%0d expected 33", name, busyCycles);
        end
        checks++;
        if (earlyDone !== 1'b0) begin
            errors++;
            $display("FAIL %s early_done: md_done seen while busy, expected none", name);
        end
        checks++;
        if (hiloMoved !== 1'b0) begin
            errors++;
            $display("FAIL %s hilo_hold: HI/LO changed while busy, expected %h/%h", name, hi0, lo0);
        end
        checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_cycle: busy=%b done=%b expected busy=0 done=1", name, md_busy, md_done);
        end
        checks++;
        if (hiE !== expHi) begin
            errors++;
            $display("FAIL %s hi: hiE=%h expected %h (rs=%h rt=%h op=%0d)", name, hiE, expHi, a, b, op);
        end
        checks++;
        if (loE !== expLo) begin
            errors++;
            $display("FAIL %s lo: loE=%h expected %h (rs=%h rt=%h op=%0d)", name, loE, expLo, a, b, op);
        end
    endtask

    task automatic test_reset();
        RESET_N   = 1'b0;
        md_startE = 1'b1;
        md_opE    = MD_MULTU;
        rs_valueE = $urandom;
        rt_valueE = $urandom;
        tick();
        tick();
        checks++;
        if (hiE !== 32'd0 || loE !== 32'd0 || md_busy !== 1'b0 || md_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b expected all zero", hiE, loE, md_busy, md_done);
        end
        md_startE = 1'b0;
        RESET_N   = 1'b1;
        tick();
        expHi = '0;
        expLo = '0;
    endtask

    task automatic test_multu_max();
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0);
        checks++;
        if (hiE !== 32'hFFFF_FFFE || loE !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_max_const: hi=%h lo=%h expected fffffffe/00000001", hiE, loE);
        end
        tick();
        checks++;
        if (md_done !== 1'b0) begin
            errors++;
            $display("FAIL multu_done_once: md_done=%b expected 0", md_done);
        end
    endtask

    task automatic test_mult_signed();
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'h0000_0005, "mult_signed", 1'b0);
        checks++;
        if (hiE !== 32'hFFFF_FFFF || loE !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL mult_signed_const: hi=%h lo=%h expected ffffffff/fffffff1", hiE, loE);
        end
    endtask

    task automatic test_div_pair();
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0);
        checks++;
        if (hiE !== 32'hFFFF_FFFF || loE !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_neg_const: hi=%h lo=%h expected ffffffff/fffffffd", hiE, loE);
        end
        run_op(MD_DIVU, 32'd7, 32'd2, "divu_small", 1'b0);
        checks++;
        if (hiE !== 32'd1 || loE !== 32'd3) begin
            errors++;
            $display("FAIL divu_small_const: hi=%h lo=%h expected 00000001/00000003", hiE, loE);
        end
    endtask

    task automatic test_div_corner();
        run_op(MD_DIV, 32'h1234_5678, 32'd0, "div_zero", 1'b0);
        checks++;
        if (hiE !== 32'h1234_5678 || loE !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_zero_const: hi=%h lo=%h expected 12345678/ffffffff", hiE, loE);
        end
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
        checks++;
        if (hiE !== 32'd0 || loE !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_ovf_const: hi=%h lo=%h expected 00000000/80000000", hiE, loE);
        end
        run_op(MD_DIV, 32'hFFFF_FF00, 32'd0, "div_zero_neg", 1'b0);
        run_op(MD_DIVU, 32'hDEAD_BEEF, 32'd0, "divu_zero", 1'b0);
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] v;
        tick();
        md_startE = 1'b1;
        md_opE    = MD_MTHI;
        rs_valueE = 32'hCAFE_F00D;
        rt_valueE = $urandom;
        tick();
        md_startE = 1'b0;
        expHi = 32'hCAFE_F00D;
        checks++;
        if (hiE !== expHi || loE !== expLo || md_busy !== 1'b0 || md_done !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b expected %h/%h busy=0 done=0",
                     hiE, loE, md_busy, md_done, expHi, expLo);
        end
        v = $urandom;
        md_startE = 1'b1;
        md_opE    = MD_MTLO;
        rs_valueE = v;
        tick();
        md_startE = 1'b0;
        expLo = v;
        checks++;
        if (hiE !== expHi || loE !== expLo || md_busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b expected %h/%h busy=0", hiE, loE, md_busy, expHi, expLo);
        end
        md_startE = 1'b1;
        md_opE    = 3'd6;
        rs_valueE = $urandom;
        tick();
        md_startE = 1'b0;
        checks++;
        if (hiE !== expHi || loE !== expLo || md_busy !== 1'b0 || md_done !== 1'b0) begin
            errors++;
            $display("FAIL reserved_op: hi=%h lo=%h busy=%b done=%b expected unchanged idle",
                     hiE, loE, md_busy, md_done);
        end
    endtask

    task automatic test_ignored_start();
        run_op(MD_MULTU, 32'h0001_0003, 32'h0000_0007, "ignored_start", 1'b1);
        tick();
        checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || hiE !== expHi || loE !== expLo) begin
            errors++;
            $display("FAIL ignored_start_after: busy=%b done=%b hi=%h lo=%h expected idle %h/%h",
                     md_busy, md_done, hiE, loE, expHi, expLo);
        end
    endtask

    task automatic test_back_to_back();
        run_op(MD_DIVU, 32'd1000, 32'd7, "b2b_0", 1'b0);
        run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, "b2b_1", 1'b0);
        run_op(MD_DIV, 32'd100, 32'hFFFF_FFF9, "b2b_2", 1'b0);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op(op, a, b, "random", 1'b0);
        end
    endtask

    task automatic test_reset_mid_op();
        bit sawDone;
        bit sawBusy;
        tick();
        md_startE = 1'b1;
        md_opE    = MD_MTHI;
        rs_valueE = 32'h1111_2222;
        tick();
        md_opE    = MD_MTLO;
        rs_valueE = 32'h3333_4444;
        tick();
        md_opE    = MD_DIVU;
        rs_valueE = $urandom;
        rt_valueE = 32'd3;
        tick();
        md_startE = 1'b0;
        repeat (9) tick();
        checks++;
        if (md_busy !== 1'b1 || hiE !== 32'h1111_2222 || loE !== 32'h3333_4444) begin
            errors++;
            $display("FAIL pre_reset: busy=%b hi=%h lo=%h expected busy=1 11112222/33334444", md_busy, hiE, loE);
        end
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        expHi = '0;
        expLo = '0;
        checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || hiE !== 32'd0 || loE !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h expected all zero", md_busy, md_done, hiE, loE);
        end
        sawDone = 1'b0;
        sawBusy = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (md_done !== 1'b0) sawDone = 1'b1;
            if (md_busy !== 1'b0) sawBusy = 1'b1;
            tick();
        end
        checks++;
        if (sawDone !== 1'b0 || sawBusy !== 1'b0 || hiE !== 32'd0 || loE !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort: done_seen=%b busy_seen=%b hi=%h lo=%h expected 0 0 0 0",
                     sawDone, sawBusy, hiE, loE);
        end
    endtask

    initial begin
        RESET_N   = 1'b0;
        md_startE = 1'b0;
        md_opE    = 3'd0;
        rs_valueE = '0;
        rt_valueE = '0;
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div_pair();
        test_div_corner();
        test_mthi_mtlo();
        test_ignored_start();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Execute-stage multi-cycle multiply/divide unit with the architectural HI/LO registers.
- Consumes the operand and control values that the ID/EX pipeline register presents in EX.
- Runs MULT/MULTU/DIV/DIVU iteratively, one bit per cycle.
- Asserts a busy flag so the hazard logic can hold dependent instructions in ID.
- Supplies HI/LO values to the EX result mux for MFHI/MFLO.

## Interface
Parameters
- XLEN, 32, operand width; only 32 is supported.

Ports
- CLOCK  in  1  pipeline clock; all state changes on its rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- md_startE  in  1  valid multiply/divide-class operation in EX this cycle.
- md_opE  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved, treated as no-op.
- rs_valueE  in  XLEN  forwarded rs operand (dividend or multiplicand).
- rt_valueE  in  XLEN  forwarded rt operand (divisor or multiplier).
- hiE  out  XLEN  architectural HI register.
- loE  out  XLEN  architectural LO register.
- md_busy  out  1  iterative operation in progress; decoded directly from state.
- md_done  out  1  one-cycle pulse: HI/LO just took a multiply/divide result.

## Operation
- FSM states: IDLE, CALC, SIGN.
- IDLE:
  - md_startE with op 0-3: capture operands, clear the 6-bit counter, go to CALC.
  - md_startE with op 4 or 5: write rs_valueE into HI or LO at that edge and stay in IDLE. No busy, no done.
  - md_startE while not IDLE: ignored. The hazard unit must prevent this case.
- Operand capture:
  - Signed ops capture magnitudes (two's-complement negate if negative). The result-sign flag is rs[31]^rt[31]; the remainder-sign flag is rs[31].
  - Unsigned ops capture values as-is with both flags cleared.
  - After the capture edge, operand input changes have no effect.
- CALC, 32 cycles (counter 0..31):
  - Multiply: shift-add into a 64-bit accumulator, one multiplier bit per cycle.
  - Divide: restoring division; a 64-bit {remainder, quotient} register shifts left one bit per cycle with trial subtract.
  - At count 31, go to SIGN.
- SIGN, 1 cycle:
  - Apply sign flags: negate the 64-bit product; negate the quotient; negate the remainder if the remainder flag is set.
  - Write HI/LO, go to IDLE, set md_done for the next cycle.
- Results:
  - MULT/MULTU: {HI,LO} = 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder. The remainder takes the dividend's sign.
- Divide by zero: result is fixed as HI = rs, LO = 0xFFFFFFFF for both DIV and DIVU. The unit still takes the full 33 busy cycles.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, which is the natural magnitude-algorithm result. No trap.
- Reset (RESET_N low at an edge):
  - state IDLE, HI = LO = 0, md_busy = 0, md_done = 0, counter = 0.
  - A reset during CALC or SIGN aborts the operation; HI/LO still become 0 and no done pulse is produced.

## Timing
- Start sampled at edge T. md_busy is high in cycles T+1 through T+33 (32 CALC + 1 SIGN).
- HI/LO change at the edge ending cycle T+33 and are valid in cycle T+34. In that cycle md_done = 1 and md_busy = 0.
- Back-to-back operations: the earliest next start is sampled at the edge ending cycle T+34.
- MTHI/MTLO: the value is visible on hiE/loE in the cycle after the sampling edge.
- hiE and loE are register outputs with no combinational path from the inputs. md_busy depends only on state.
- HI/LO are unchanged in every cycle except the SIGN-exit edge, the MTHI/MTLO edge, and reset.

## Structure
- Package md_pkg holds:
  - the md_opE encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - the state encoding (MD_IDLE, MD_CALC, MD_SIGN);
  - XLEN and MD_ITER = 32.
- One sub-module, md_negate: a combinational conditional two's-complement negate, parameterised by width. It is instantiated for operand magnitudes (32) and result fix-up (64/32).
- The FSM, counter and datapath registers stay in ex_muldiv_unit.

## Test plan
- Unsigned multiply: MULTU 0xFFFFFFFF × 0xFFFFFFFF at T.
  - md_busy high for exactly 33 cycles.
  - In cycle T+34: HI = 0xFFFFFFFE, LO = 0x00000001, md_done pulses once.
- Signed multiply: MULT 0xFFFFFFFD × 0x00000005 (-3 × 5) → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- Division pair:
  - DIV 0xFFFFFFF9 / 2 (-7 / 2) → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7 / 2 → LO = 3, HI = 1.
- Division corner cases:
  - DIV 0x12345678 / 0 → HI = 0x12345678, LO = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- MTHI and ignored start:
  - MTHI rs = 0xCAFEF00D in IDLE → hiE = 0xCAFEF00D next cycle, md_busy stays 0.
  - MULTU issued while busy is ignored; the first result is unaffected.
- Reset mid-operation: RESET_N low at T+10 during a DIVU → next cycle state IDLE, md_busy = 0, HI = LO = 0, and md_done never pulses.
